alu_pipe: RTL and testbench

Parametrised, handshaked successor to the team's 32-bit registered ALU. Adds a WIDTH parameter, valid/ready flow control on input and output, status flags, shifts and compares, and an optional iterative multiplier. Sits between an operand-issue stage and a result-writeback stage. Either side may stall.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 54 +++++
 rtl/alu_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for alu_pipe and its multiplier.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_NOR   = 4'b0101,
        OP_SLT   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_SLL   = 4'b1000,
        OP_SRL   = 4'b1001,
        OP_SRA   = 4'b1010,
        OP_PASSB = 4'b1011,
        OP_MUL   = 4'b1100,
        OP_ILL_D = 4'b1101,
        OP_ILL_E = 4'b1110,
        OP_ILL_F = 4'b1111
    } op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle for WIDTH cycles,
// returning the low WIDTH bits of a*b. done is high during the final step with product valid.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // Down-counter reaches zero on the last step; the product is taken combinationally then.
    assign done    = busy && (cnt == '0);
    assign product = acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= CW'(WIDTH - 1);
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= {mcand[WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; ALU_MUL_EN compiles in the iterative multiplier.
// state | meaning
// IDLE  | accepting ops; non-MUL results registered in one cycle
// MUL   | multiplier stepping, in_ready low until the product is registered
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SW = $clog2(WIDTH);

    op_t              op;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic [3:0]       res_flags;
    logic             res_err;
    logic             res_c;
    logic             res_v;
    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    alu_state_t       state;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r, input logic c,
                                              input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_N] = r[WIDTH-1];
        return f;
    endfunction

    assign op    = op_t'(sel);
    assign shamt = b[SW-1:0];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (op)
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOR:   res = ~(a | b);
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:   res = a << shamt;
            OP_SRL:   res = a >> shamt;
            OP_SRA:   res = $unsigned($signed(a) >>> shamt);
            OP_PASSB: res = b;
            default:  res_err = 1'b1;
        endcase
        res_flags = res_err ? 4'b0000 : pack_flags(res, res_c, res_v);
    end

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == IDLE) && !mul_busy && (!out_valid || out_ready);

`ifdef ALU_MUL_EN
    assign is_mul = (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && is_mul) state <= MUL;
                MUL:     if (mul_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
    assign state    = IDLE;
`endif

    // A MUL accept drains the old result but produces nothing until the multiplier finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
            err       <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1;
            out       <= res;
            flags     <= res_flags;
            err       <= res_err;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out       <= mul_prod;
            flags     <= pack_flags(mul_prod, 1'b0, 1'b0);
            err       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: behavioural reference with a result queue, directed
// corner cases, reset-abort checks and randomized traffic with random back-pressure.
module tb_alu_pipe;

    localparam int W = 32;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    sel = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out;
    logic [3:0]    flags;
    logic          err;

    logic          in_valid8 = 1'b0;
    logic          in_ready8;
    logic [7:0]    a8 = '0;
    logic [7:0]    b8 = '0;
    logic [3:0]    sel8 = '0;
    logic          out_valid8;
    logic          out_ready8 = 1'b1;
    logic [7:0]    out8;
    logic [3:0]    flags8;
    logic          err8;

    alu_pipe #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .flags(flags), .err(err)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sel(sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out(out8), .flags(flags8), .err(err8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [36:0] r;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference result as {err, n, v, c, z, out} from plain 64-bit arithmetic.
    function automatic logic [36:0] model(input logic [3:0] s, input logic [31:0] x,
                                          input logic [31:0] y);
        longint unsigned ux, uy, t;
        longint          sx, sy, st;
        logic [31:0]     r;
        logic [4:0]      sh;
        bit              c, v, e;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        sh = y[4:0];
        r = '0; c = 0; v = 0; e = 0;
        case (s)
            4'h0: r = x & y;
            4'h1: r = x | y;
            4'h2: r = x ^ y;
            4'h3: begin
                t = ux + uy; r = t[31:0]; c = (t > 64'hFFFF_FFFF);
                st = sx + sy; v = (st != longint'($signed(r)));
            end
            4'h4: begin
                r = x - y; c = (ux < uy);
                st = sx - sy; v = (st != longint'($signed(r)));
            end
            4'h5: r = ~(x | y);
            4'h6: r = (sx < sy) ? 32'd1 : 32'd0;
            4'h7: r = (ux < uy) ? 32'd1 : 32'd0;
            4'h8: r = x << sh;
            4'h9: r = x >> sh;
            4'hA: begin st = sx >>> sh; r = st[31:0]; end
            4'hB: r = y;
            4'hC: begin
                if (MUL_EN) begin t = ux * uy; r = t[31:0]; end
                else e = 1;
            end
            default: e = 1;
        endcase
        if (e) return {1'b1, 4'b0000, 32'h0};
        return {1'b0, r[31], v, c, (r == 32'h0), r};
    endfunction

    // One clock: check outputs against the queue head, then drive the next inputs.
    task automatic cycle(input bit iv, input logic [3:0] s, input logic [31:0] x,
                         input logic [31:0] y, input bit ordy);
        bit   ev, exp_rdy;
        exp_t f;
        @(negedge clk);
        ev = (q.size() > 0) && (cyc >= q[0].due);
        chk("out_valid", {63'h0, out_valid}, {63'h0, ev});
        if (ev && out_valid) begin
            chk("out", {32'h0, out}, {32'h0, q[0].r[31:0]});
            chk("flags", {60'h0, flags}, {60'h0, q[0].r[35:32]});
            chk("err", {63'h0, err}, {63'h0, q[0].r[36]});
        end
        in_valid = iv; sel = s; a = x; b = y; out_ready = ordy;
        #1;
        exp_rdy = ((q.size() == 0) || ev) && (!ev || ordy);
        chk("in_ready", {63'h0, in_ready}, {63'h0, exp_rdy});
        if (ev && ordy) void'(q.pop_front());
        if (iv && exp_rdy) begin
            f.r   = model(s, x, y);
            f.due = cyc + 1 + ((s == 4'hC && MUL_EN) ? W : 0);
            q.push_back(f);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b0;
        q.delete();
        #2;
        chk("out_valid_in_reset", {63'h0, out_valid}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
        #1;
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_out", {32'h0, out}, 64'h0);
        chk("rst_flags", {60'h0, flags}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        do_reset();

        // Pin the reference model to hand-computed results.
        chk("model_add", {27'h0, model(4'h3, 32'hFFFF_FFFF, 32'h1)}, {27'h0, 1'b0, 4'b0011, 32'h0});
        chk("model_sub", {27'h0, model(4'h4, 32'h8000_0000, 32'h1)}, {27'h0, 1'b0, 4'b0100, 32'h7FFF_FFFF});
        chk("model_slt", {27'h0, model(4'h6, 32'hFFFF_FFFF, 32'h1)}, {27'h0, 1'b0, 4'b0000, 32'h1});
        chk("model_sltu", {27'h0, model(4'h7, 32'hFFFF_FFFF, 32'h1)}, {27'h0, 1'b0, 4'b0001, 32'h0});
        chk("model_sra", {27'h0, model(4'hA, 32'h8000_0000, 32'h24)}, {27'h0, 1'b0, 4'b1000, 32'hF800_0000});
        chk("model_srl", {27'h0, model(4'h9, 32'h8000_0000, 32'h24)}, {27'h0, 1'b0, 4'b0000, 32'h0800_0000});
        chk("model_ill", {27'h0, model(4'hE, 32'h1234_5678, 32'h9)}, {27'h0, 1'b1, 4'b0000, 32'h0});
`ifdef ALU_MUL_EN
        chk("model_mul", {27'h0, model(4'hC, 32'd7, 32'd6)}, {27'h0, 1'b0, 4'b0000, 32'd42});
`else
        chk("model_mul", {27'h0, model(4'hC, 32'd7, 32'd6)}, {27'h0, 1'b1, 4'b0000, 32'h0});
`endif

        // WIDTH=8 signed-overflow corner.
        @(negedge clk);
        in_valid8 = 1'b1; sel8 = 4'h3; a8 = 8'h7F; b8 = 8'h01;
        @(negedge clk);
        in_valid8 = 1'b0;
        chk("w8_valid", {63'h0, out_valid8}, 64'h1);
        chk("w8_out", {56'h0, out8}, 64'h80);
        chk("w8_flags", {60'h0, flags8}, 64'hC);
        chk("w8_err", {63'h0, err8}, 64'h0);

        // Directed ops through the 32-bit instance.
        cycle(1, 4'h3, 32'hFFFF_FFFF, 32'h1, 1);
        cycle(1, 4'h4, 32'h8000_0000, 32'h1, 1);
        cycle(1, 4'h6, 32'hFFFF_FFFF, 32'h1, 1);
        cycle(1, 4'h7, 32'hFFFF_FFFF, 32'h1, 1);
        cycle(1, 4'hA, 32'h8000_0000, 32'h24, 1);
        cycle(1, 4'h9, 32'h8000_0000, 32'h24, 1);
        cycle(1, 4'hE, 32'h1234_5678, 32'h9, 1);
        cycle(1, 4'hC, 32'd7, 32'd6, 1);
        repeat (W + 3) cycle(0, 4'h0, 32'h0, 32'h0, 1);

        // Back-pressure: second ADD waits, then accept and drain in the same cycle.
        cycle(1, 4'h3, 32'd1, 32'd1, 0);
        cycle(1, 4'h3, 32'd2, 32'd2, 0);
        cycle(1, 4'h3, 32'd2, 32'd2, 0);
        cycle(1, 4'h3, 32'd2, 32'd2, 1);
        cycle(0, 4'h0, 32'h0, 32'h0, 1);
        cycle(0, 4'h0, 32'h0, 32'h0, 1);

        // Reset discards a held result.
        cycle(1, 4'h3, 32'd5, 32'd5, 0);
        cycle(0, 4'h0, 32'h0, 32'h0, 0);
        do_reset();
        repeat (3) cycle(0, 4'h0, 32'h0, 32'h0, 1);

`ifdef ALU_MUL_EN
        // Reset mid-multiply aborts it: no result ever appears.
        cycle(1, 4'hC, 32'd7, 32'd6, 1);
        repeat (9) cycle(0, 4'h0, 32'h0, 32'h0, 1);
        do_reset();
        repeat (W + 8) cycle(0, 4'h0, 32'h0, 32'h0, 1);
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd(),
                  $urandom_range(0, 9) < 7);
        end
        repeat (W + 4) cycle(0, 4'h0, 32'h0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
